// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Every output is decoded from state flops, so no input reaches an output combinationally.
module pipe_skid_reg #(
  parameter int unsigned DATA_W     = 97,
  parameter bit          FLUSH_ZERO = 1'b1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // 2'b11 is never reached; it decodes as StFull.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StHalf  = 2'b01,
    StFull  = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic [DATA_W-1:0]   s_data_q, s_data_d;
  logic                in_ready_q, in_ready_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                in_xfer, out_xfer;

  assign out_valid = (state_q != StEmpty);
  assign in_ready  = in_ready_q;
  assign out_data  = m_data_q;
  assign stall_cnt = stall_cnt_q;
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    occupancy = 2'd2;
    case (state_q)
      StEmpty: occupancy = 2'd0;
      StHalf:  occupancy = 2'd1;
      default: occupancy = 2'd2;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          state_d  = StHalf;
          m_data_d = in_data;
        end
      end
      StHalf: begin
        if (in_xfer && out_xfer) begin
          m_data_d = in_data;
        end else if (in_xfer) begin
          state_d  = StFull;
          s_data_d = in_data;
        end else if (out_xfer) begin
          state_d = StEmpty;
        end
      end
      default: begin
        if (out_xfer) begin
          state_d  = StHalf;
          m_data_d = s_data_q;
        end
      end
    endcase

    if (flush) begin
      state_d = StEmpty;
    end

    // Keep invalid entries at zero so out_data reads 0 whenever out_valid is low.
    if (FLUSH_ZERO) begin
      if (state_d == StEmpty) begin
        m_data_d = '0;
      end
      if (state_d != StFull) begin
        s_data_d = '0;
      end
    end

    in_ready_d = (state_d == StEmpty) || (state_d == StHalf);

    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      m_data_q    <= '0;
      s_data_q    <= '0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      m_data_q    <= m_data_d;
      s_data_q    <= s_data_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: two instances (zeroing and stale-data variants) share stimulus
// and are checked every cycle against a 2-deep FIFO reference model.
module tb_pipe_skid_reg;

  localparam int unsigned DW = 16;

  logic          clk, rst, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;

  logic          z_in_ready, z_out_valid;
  logic [DW-1:0] z_out_data;
  logic [1:0]    z_occ;
  logic [2:0]    z_stall;

  logic          n_in_ready, n_out_valid;
  logic [DW-1:0] n_out_data;
  logic [1:0]    n_occ;
  logic [7:0]    n_stall;

  pipe_skid_reg #(.DATA_W(DW), .FLUSH_ZERO(1'b1), .CNT_W(3)) u_dut_z (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (z_in_ready),
    .in_data   (in_data),
    .out_valid (z_out_valid),
    .out_ready (out_ready),
    .out_data  (z_out_data),
    .occupancy (z_occ),
    .stall_cnt (z_stall)
  );

  pipe_skid_reg #(.DATA_W(DW), .FLUSH_ZERO(1'b0), .CNT_W(8)) u_dut_n (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (n_in_ready),
    .in_data   (in_data),
    .out_valid (n_out_valid),
    .out_ready (out_ready),
    .out_data  (n_out_data),
    .occupancy (n_occ),
    .stall_cnt (n_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: FIFO of held payloads (capacity 2) and an unbounded stall count.
  logic [DW-1:0] q[$];
  longint unsigned stall_model;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input longint unsigned v, input longint unsigned max);
    return (v > max) ? 32'(max) : 32'(v);
  endfunction

  task automatic step(input logic r, input logic f, input logic iv, input logic [DW-1:0] d,
                      input logic ordy);
    int sz;
    logic out_x, in_x;
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    @(negedge clk);
    sz = q.size();
    chk("z_in_ready", 32'(z_in_ready), 32'(sz < 2));
    chk("z_out_valid", 32'(z_out_valid), 32'(sz > 0));
    chk("z_occupancy", 32'(z_occ), 32'(sz));
    chk("z_out_data", 32'(z_out_data), (sz > 0) ? 32'(q[0]) : 32'd0);
    chk("z_stall_cnt", 32'(z_stall), sat(stall_model, 7));
    chk("n_in_ready", 32'(n_in_ready), 32'(sz < 2));
    chk("n_out_valid", 32'(n_out_valid), 32'(sz > 0));
    chk("n_occupancy", 32'(n_occ), 32'(sz));
    chk("n_stall_cnt", 32'(n_stall), sat(stall_model, 255));
    if (sz > 0) chk("n_out_data", 32'(n_out_data), 32'(q[0]));
    @(posedge clk);
    out_x = (sz > 0) && ordy;
    in_x  = iv && (sz < 2);
    if (r) begin
      q.delete();
      stall_model = 0;
    end else begin
      if ((sz > 0) && !ordy) stall_model++;
      if (f) begin
        q.delete();
      end else begin
        if (out_x) void'(q.pop_front());
        if (in_x) q.push_back(d);
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    stall_model = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values, then stream 1..4 with out_ready high.
    step(0, 0, 0, 16'h0, 1);
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 16'(i), 1);
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);

    // Skid: 10 presented, then out_ready drops; 11 lands in S, 12 held upstream.
    step(0, 0, 1, 16'd10, 1);
    step(0, 0, 1, 16'd11, 0);
    step(0, 0, 1, 16'd12, 0);
    step(0, 0, 1, 16'd12, 0);
    step(0, 0, 1, 16'd12, 1);
    step(0, 0, 1, 16'd12, 1);
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);

    // Flush in FULL with a payload offered.
    step(0, 0, 1, 16'hA, 0);
    step(0, 0, 1, 16'hB, 0);
    step(0, 1, 1, 16'hC, 0);
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);

    // Flush coincident with an output transfer.
    step(0, 0, 1, 16'h5, 1);
    step(0, 1, 0, 16'h0, 1);
    step(0, 0, 1, 16'h6, 1);
    step(0, 0, 0, 16'h0, 1);

    // Stall counter saturation (3-bit instance reaches 7 and holds).
    step(0, 0, 1, 16'h7, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 1);

    // Reset together with flush while FULL.
    step(0, 0, 1, 16'h21, 0);
    step(0, 0, 1, 16'h22, 0);
    step(1, 1, 1, 16'h23, 0);
    step(0, 0, 0, 16'h0, 0);

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(15) == 0), 1'($urandom),
           16'($urandom), ($urandom_range(3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer. It replaces the fixed-width IF/ID-style stage registers and can sit between any two stages of the in-order pipeline (IF→ID, ID→EX, EX→LS). It carries an opaque payload, supports a synchronous flush that inserts a bubble, and registers every output, including the backpressure signal `in_ready`. It also exposes an occupancy count and a saturating backpressure counter for performance analysis.

## Interface
- `DATA_W`, default 97: payload width. The default packs {jump[96], pc[95:32], inst[31:0]}.
- `FLUSH_ZERO`, default 1: if 1, `out_data` reads 0 whenever `out_valid`=0, and the data registers are zeroed on reset and flush. If 0, data registers hold stale contents.
- `CNT_W`, default 32: width of `stall_cnt`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  discard all held entries; highest priority after `rst`.
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  stage can accept; driven from a register.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  downstream payload valid; registered.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_W  downstream payload; registered.
- `occupancy`  out  2  number of valid entries, 0..2.
- `stall_cnt`  out  CNT_W  cycles with `out_valid`=1 and `out_ready`=0; saturates at all-ones.

## Operation
- Storage consists of a main entry M (drives `out_*`) and a skid entry S. Each has a valid bit.
- Handshake events:
  - Input transfer: `in_valid` & `in_ready`.
  - Output transfer: `out_valid` & `out_ready`.
- Output signals: `out_valid`=M.valid; `in_ready`=!S.valid; `occupancy`=M.valid+S.valid.
- States and transitions, evaluated on the rising edge of `clk`:
  - EMPTY (M=0, S=0):
    - input transfer → HALF, M←in_data.
    - otherwise stay.
  - HALF (M=1, S=0):
    - input and output transfer → HALF, M←in_data.
    - input transfer only → FULL, S←in_data.
    - output transfer only → EMPTY.
    - neither → stay.
  - FULL (M=1, S=1), `in_ready`=0:
    - output transfer → HALF, M←S.
    - otherwise stay; M and S hold.
- S is never written unless M is valid and M is not draining in the same cycle, so ordering is strictly FIFO.
- `flush`=1:
  - Next state is EMPTY regardless of `in_valid`/`out_ready`.
  - A payload offered in the flush cycle is discarded, even if `in_ready`=1.
  - An output transfer in the flush cycle counts as completed; downstream owns that payload.
  - With `FLUSH_ZERO`=1, M and S data are cleared to 0.
- `rst`=1 forces EMPTY and clears `stall_cnt`. `rst` takes priority over `flush`.
- `stall_cnt`:
  - Increments by 1 each cycle with `out_valid`=1 and `out_ready`=0, including a flush cycle.
  - Holds at 2^CNT_W−1.
  - Cleared only by `rst`.
- Illegal state (M=0, S=1) is unreachable. If forced, the block treats it as FULL.

## Timing
- Reset values: `out_valid`=0, `in_ready`=1, `out_data`=0, `occupancy`=0, `stall_cnt`=0.
- Latency: a payload accepted at edge N appears on `out_data` with `out_valid`=1 after edge N (visible in cycle N+1).
- Throughput: 1 payload/cycle sustained while `out_ready`=1. The stage never leaves EMPTY↔HALF in this case.
- Backpressure:
  - `out_ready` falling is absorbed by S with no loss.
  - `in_ready` drops one cycle later, after S fills.
  - `in_ready` rises the cycle after the edge at which FULL drains to HALF.
- No combinational path from `out_ready` or `in_valid` to `in_ready`, and no combinational path from inputs to `out_valid`/`out_data`.
- After flush: `out_valid`=0 and `in_ready`=1 in the next cycle. A new payload may be accepted in that cycle.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- Reset then stream: drive `in_data`=1,2,3,4 on consecutive cycles with `out_ready`=1 → `out_data`=1,2,3,4 one cycle later. `occupancy` stays 1, `in_ready` stays 1, `stall_cnt`=0.
- Skid: stream 10,11,12 and drop `out_ready` the cycle 10 is presented.
  - 10 holds on the output and 11 lands in S; `in_ready`=0 the next cycle and 12 is held upstream; `occupancy`=2.
  - Raise `out_ready` → output 10,11,12 in order, no loss or duplication.
- Flush in FULL: fill with 0xA, 0xB, then assert `flush` with `in_valid`=1, `in_data`=0xC → next cycle `out_valid`=0, `occupancy`=0, `in_ready`=1, and 0xC is never emitted. With `FLUSH_ZERO`=1, `out_data`=0.
- Flush with output transfer: `out_valid`=1 (0x5), `out_ready`=1, `flush`=1 in the same cycle → 0x5 counts as consumed exactly once, and the stage is EMPTY next cycle.
- Stall counter: `CNT_W`=3, hold `out_valid`=1 with `out_ready`=0 for 10 cycles → `stall_cnt` reads 7 and holds. `rst` → 0.
- Reset mid-operation: in FULL, assert `rst` for 1 cycle together with `flush` → all outputs at their reset values next cycle. `FLUSH_ZERO`=0 variant: `out_data` may be stale but `out_valid`=0.
